// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory write-port arbiter: FSM state encoding,
// default bus widths and a constant log2 helper for index widths.
// No ports; imported by the interface, the picker and the arbiter top.
package mem_arb_pkg;

  // One-hot so the debug output can expose the state register directly.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_WAIT = 3'b010,
    S_DONE = 3'b100
  } state_t;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 16;

  // Ceiling log2, minimum 1 so a 2-requester build still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the write-port arbiter.
// Ports: req/req_addr/req_wdata/req_ack/req_err (requesters), mem_we/mem_addr/
// mem_wdata/mem_rdy (RAM controller), grant_id/busy/debug (status).
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int GW   = clog2(NREQ)
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    req_err;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_rdy;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic [2:0]         debug;

  // Arbiter side.
  modport slave (
    input  req, req_addr, req_wdata, mem_rdy,
    output req_ack, req_err, mem_we, mem_addr, mem_wdata, grant_id, busy, debug
  );

  // Environment side: requesters plus the RAM controller.
  modport master (
    output req, req_addr, req_wdata, mem_rdy,
    input  req_ack, req_err, mem_we, mem_addr, mem_wdata, grant_id, busy, debug
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from
// pointer+1, wrapping modulo NREQ.
// Ports: req, pointer in; winner (index), any_req out.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   pointer,
  output logic [GW-1:0]   winner,
  output logic            any_req
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  always_comb begin
    int pos;
    pos     = 0;
    winner  = '0;
    any_req = |req;
    // Walk offsets from farthest to nearest; the last hit is the nearest one
    // after the pointer, which is the round-robin winner.
    for (int off = NREQ; off >= 1; off--) begin
      pos = int'(pointer) + off;
      if (pos >= NREQ) pos = pos - NREQ;
      if ((req & (ONE << pos)) != '0) winner = GW'(pos);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one write-only memory port among NREQ requesters:
// latches winner address/data, waits for mem_rdy (with stall timeout), strobes
// mem_we for one cycle and acks. Ports: clk, sys_rst, bus (slave modport).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10,
  parameter int GW      = clog2(NREQ)
) (
  input  logic               clk,
  input  logic               sys_rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [NREQ-1:0] ONE     = NREQ'(1);
  localparam logic [TW-1:0]   TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   grant;
  logic [TW-1:0]   cnt;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] err_q;
  logic            busy_q;
  logic [GW-1:0]   winner;
  logic            any_req;

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .req     (bus.req),
    .pointer (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      ptr         <= GW'(NREQ - 1);  // requester 0 wins first after reset
      grant       <= '0;
      cnt         <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            mem_addr_q  <= bus.req_addr[int'(winner)*AW +: AW];
            mem_wdata_q <= bus.req_wdata[int'(winner)*DW +: DW];
            grant       <= winner;
            cnt         <= '0;
            busy_q      <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rdy) begin
            mem_we_q <= 1'b1;
            ack_q    <= ONE << grant;
            state    <= S_DONE;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            // Abort: complete the handshake with an error, never write.
            ack_q <= ONE << grant;
            err_q <= ONE << grant;
            state <= S_DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + TW'(1);
          end
        end
        S_DONE: begin
          mem_we_q <= 1'b0;
          ack_q    <= '0;
          err_q    <= '0;
          ptr      <= grant;
          busy_q   <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          ack_q    <= '0;
          err_q    <= '0;
          busy_q   <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.req_ack   = ack_q;
  assign bus.req_err   = err_q;
  assign bus.grant_id  = grant;
  assign bus.busy      = busy_q;
  assign bus.debug     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the driver predicts each transaction
// from a round-robin reference model and queues it; a monitor checks every ack.
module tb_mem_port_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 16;
  localparam int TO   = 8;
  localparam int TW   = 10;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [15:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic [3:0]  pend = '0;
  int          ptr = NREQ - 1;
  logic [31:0] a[NREQ];
  logic [15:0] d[NREQ];

  mem_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .GW(2)) bus ();

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO), .TW(TW), .GW(2)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first pending requester after the last granted one.
  function automatic int model_pick(input logic [3:0] p, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      int i;
      i = (last + off) % NREQ;
      if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive(input logic [3:0] r);
    bus.req = r;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW]  = a[i];
      bus.req_wdata[i*DW +: DW] = d[i];
    end
  endtask

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_txn(input logic [3:0] add, input int stall, input bit keep,
                         input bit chg, input bit rnd);
    int   w;
    int   k;
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      if (add[i] && !pend[i]) begin
        pend[i] = 1'b1;
        if (rnd) begin
          a[i] = $urandom;
          d[i] = 16'($urandom);
        end
      end
    end
    if (pend == '0) begin
      pend[0] = 1'b1;
      a[0] = $urandom;
      d[0] = 16'($urandom);
    end
    drive(pend);
    bus.mem_rdy = 1'($urandom);
    w = model_pick(pend, ptr);
    k = (stall < TO) ? stall : TO;
    e.id   = w;
    e.addr = a[w];
    e.data = d[w];
    e.err  = (stall >= TO);
    e.cyc  = cyc + 1 + k + ((stall < TO) ? 1 : 0);
    q.push_back(e);
    @(negedge clk);
    if (chg) begin
      // Address/data only matter at grant; requester may also drop req now.
      a[w] = $urandom;
      d[w] = 16'($urandom);
      drive(pend & ~(4'(1) << w));
    end
    for (int j = 0; j < k; j++) begin
      bus.mem_rdy = 1'b0;
      @(negedge clk);
    end
    if (stall < TO) begin
      bus.mem_rdy = 1'b1;
      @(negedge clk);
    end
    ptr = w;
    if (keep) begin
      a[w] = $urandom;
      d[w] = 16'($urandom);
    end else begin
      pend[w] = 1'b0;
    end
    drive(pend);
    bus.mem_rdy = 1'($urandom);
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_debug", 64'(bus.debug), 64'd1);
    chk("idle_ack", 64'(bus.req_ack), 64'd0);
  endtask

  // Monitor: every ack/err/we pulse must match the head of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!sys_rst && (bus.req_ack != '0 || bus.req_err != '0 || bus.mem_we)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {59'd0, bus.mem_we, bus.req_ack}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("ack_onehot", 64'(bus.req_ack), 64'(4'(1) << e.id));
        chk("err", 64'(bus.req_err), e.err ? 64'(4'(1) << e.id) : 64'd0);
        chk("mem_we", 64'(bus.mem_we), 64'(!e.err));
        chk("grant_id", 64'(bus.grant_id), 64'(e.id));
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("debug_done", 64'(bus.debug), 64'd4);
        if (!e.err) begin
          chk("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
          chk("mem_wdata", 64'(bus.mem_wdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    drive('0);
    bus.mem_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_ack_err", {56'd0, bus.req_ack, bus.req_err}, 64'd0);
    chk("rst_grant_busy", {61'd0, bus.grant_id, bus.busy}, 64'd0);
    chk("rst_debug", 64'(bus.debug), 64'd1);
    sys_rst = 1'b0;
    @(negedge clk);

    // Single request, memory ready.
    a[2] = 32'h10;
    d[2] = 16'hA55A;
    run_txn(4'b0100, 0, 1'b0, 1'b0, 1'b0);
    // All four requesting, each dropping after its ack.
    run_txn(4'b1111, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) run_txn(4'b0000, 0, 1'b0, 1'b0, 1'b1);
    // Two raised together.
    run_txn(4'b1001, 0, 1'b0, 1'b0, 1'b1);
    run_txn(4'b0000, 0, 1'b0, 1'b0, 1'b1);
    // Stall of 5 cycles with address changed during WAIT.
    run_txn(4'b0010, 5, 1'b0, 1'b1, 1'b1);
    // Timeout, then a normal transaction.
    run_txn(4'b0100, 12, 1'b0, 1'b0, 1'b1);
    run_txn(4'b0001, 0, 1'b0, 1'b0, 1'b1);
    // Exactly TIMEOUT-1 stalls still completes; exactly TIMEOUT aborts.
    run_txn(4'b1000, TO - 1, 1'b0, 1'b0, 1'b1);
    run_txn(4'b1000, TO, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of WAIT aborts silently.
    a[2] = 32'hDEAD_0000 | 32'($urandom_range(1, 255));
    d[2] = 16'h5A5A;
    pend = 4'b0100;
    drive(pend);
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1'b1;
    #1;
    chk("midrst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("midrst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("midrst_pulses", {59'd0, bus.mem_we, bus.req_ack}, 64'd0);
    chk("midrst_grant_busy", {61'd0, bus.grant_id, bus.busy}, 64'd0);
    chk("midrst_debug", 64'(bus.debug), 64'd1);
    pend = '0;
    drive(pend);
    ptr = NREQ - 1;
    @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    run_txn(4'b1001, 0, 1'b0, 1'b0, 1'b1);
    run_txn(4'b0000, 0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int sel;
      int st;
      if (pend == '0 && $urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          drive('0);
          @(negedge clk);
          chk("quiet_busy", 64'(bus.busy), 64'd0);
        end
      end
      sel = $urandom_range(0, 9);
      st  = (sel < 7) ? $urandom_range(0, 3) :
            (sel < 9) ? $urandom_range(4, 7) : $urandom_range(8, 11);
      run_txn(4'($urandom_range(0, 15)), st, ($urandom_range(0, 3) == 0),
              1'($urandom), 1'b1);
    end

    drive('0);
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single write-only memory port (mem_we / mem_addr / mem_wdata / mem_rdy) among NREQ independent requesters, such as the button/switch control logic, a pattern generator and a test sequencer.
- Uses round-robin arbitration, latches the winner's address and data, waits for mem_rdy, issues a one-cycle mem_we, then acknowledges the winner.
- Sits between the requesters and the RAM controller. Provides stall timeout and a debug state output.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 32, address width.
- DW, 16, write-data width.
- TIMEOUT, 1023, maximum consecutive WAIT cycles with mem_rdy low before abort; 0 disables the timeout.
- TW, 10, timeout counter width; TIMEOUT must be < 2**TW.

Ports:
- clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- req  in  NREQ  per-requester write request (level).
- req_addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data; requester i uses bits [i*DW +: DW].
- req_ack  out  NREQ  one-cycle completion pulse to the granted requester.
- req_err  out  NREQ  one-cycle timeout pulse, coincident with req_ack.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  AW  registered write address.
- mem_wdata  out  DW  registered write data.
- mem_rdy  in  1  memory ready to accept a write.
- grant_id  out  clog2(NREQ)  index of the current or last granted requester.
- busy  out  1  high in any state other than IDLE.
- debug  out  3  one-hot state.

Behaviour:
- Reset (async, immediate), output values:
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - req_ack=0, req_err=0.
  - grant_id=0, busy=0, state=IDLE.
  - RR pointer=NREQ-1, so requester 0 wins first.
- Reset asserted mid-transaction aborts it: no ack, no mem_we.
- All outputs are registered.
- States are one-hot: IDLE=3'b001, WAIT=3'b010, DONE=3'b100. Any illegal encoding goes to IDLE.
- IDLE:
  - If req != 0, the winner is the first set bit searching upward from pointer+1, wrapping modulo NREQ.
  - Latch req_addr/req_wdata of the winner into mem_addr/mem_wdata and set grant_id=winner.
  - Clear the timeout counter, go to WAIT.
  - If req == 0, stay in IDLE; mem_addr/mem_wdata hold their last values.
- WAIT:
  - If mem_rdy=1: mem_we<=1, req_ack[grant_id]<=1, go to DONE.
  - Else the counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 while mem_rdy=0 (i.e. TIMEOUT stall cycles): req_ack[g]<=1, req_err[g]<=1, mem_we stays 0, go to DONE.
- DONE:
  - mem_we, req_ack and req_err are high for exactly this cycle and are cleared on the next clock.
  - Pointer<=grant_id, go to IDLE.
  - req is not sampled in DONE.
- Latency: req seen in IDLE at cycle 0 → WAIT at cycle 1 → (mem_rdy=1) → DONE at cycle 2 with mem_we=1 and ack=1. Minimum 3 cycles per transaction; a back-to-back request is re-granted at cycle 3.
- Requester rules:
  - Hold req until ack.
  - Address and data only need to be valid in the grant cycle; they are latched at grant.
  - Dropping req after grant does not cancel the write.
  - req still high in the cycle after ack is treated as a new request.
- Fairness: with all requesters continuously active, grants go 0,1,2,3,0,... No requester waits more than NREQ-1 transactions.
- mem_rdy already high at WAIT entry: no wait cycle is added.
- mem_rdy toggling low→high→low: the write is taken on the first high sample, and the timeout counter does not restart.
- Width rules: req_addr/req_wdata are copied unmodified. No arithmetic except the counter (TW bits, saturating; no wrap is possible because the abort fires first).

Decomposition:
- Shared package mem_arb_pkg holds:
  - State localparams S_IDLE, S_WAIT, S_DONE.
  - A clog2 function.
  - Default widths AW_DEF=32 and DW_DEF=16.
- Sub-module rr_pick (combinational): inputs req and pointer; outputs winner index and any_req. Parameterised by NREQ.
- Everything else is in mem_port_arbiter.

Test Plan:
- Single request with mem_rdy held 1: req=4'b0100, addr=0x10, data=0xA55A at cycle 0 → mem_we=1, mem_addr=0x10, mem_wdata=0xA55A, req_ack=4'b0100, all at cycle 2; busy=0 at cycle 3.
- Round-robin: req=4'b1111 held, each requester dropping its req after its ack → grant order 0,1,2,3. Re-raising 0 and 3 together after grant 3 → 0 is granted before 3.
- Stall: mem_rdy=0 for 5 cycles after grant of requester 1 → mem_we asserted at the cycle after mem_rdy rises, single pulse, req_ack[1] coincident, req_err=0.
- Timeout: TIMEOUT=8, mem_rdy held 0 → req_ack[2]=req_err[2]=1 with mem_we never asserted; the next request is served normally.
- Reset mid-WAIT: assert sys_rst during WAIT → immediately all outputs 0 and state IDLE. After release, req=4'b1000 and req=4'b0001 raised together → requester 0 is granted first.
- Data latch: change req_addr of the granted requester during WAIT → mem_addr keeps the grant-cycle value.
